bitstream_self_write_loader: RTL and testbench

Sequencer that streams a configuration bitstream from a byte-wide synchronous memory into the fabric's self-write configuration port (`SelfWriteData`/`SelfWriteStrobe` of `eFPGA_top`). It packs four consecutive bytes into one big-endian 32-bit word and presents the word with fixed setup time. It then pulses the strobe for one cycle and holds the data for a fixed time. It replaces bench-side bitstream loops and sits beside `eFPGA_top` in emulation and on-chip boot paths, handing control to user logic once configuration completes.

---
 rtl/bitstream_self_write_loader.sv | 147 ++++++++++++++
 tb/tb_bitstream_self_write_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_self_write_loader.sv
// Streams a byte-wide bitstream memory into the fabric self-write port:
// four bytes packed big-endian per word, fixed setup, one-cycle strobe, fixed hold.
module bitstream_self_write_loader #(
    parameter int ADDR_W       = 14,
    parameter int LEN_W        = 12,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written
);

    localparam int SH_MAX  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (SH_MAX > 4) ? SH_MAX : 4;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [LEN_W-1:0]  len_r;
    logic [23:0]       bytes_r;

    // First three bytes are already shifted in; the fourth arrives on the bus.
    function automatic logic [31:0] pack_word(input logic [23:0] head, input logic [7:0] tail);
        return {head, tail};
    endfunction

    // Sequencer: state, memory read stream, word packing and self-write handshake.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            len_r           <= {LEN_W{1'b0}};
            bytes_r         <= 24'h000000;
            mem_rd_en       <= 1'b0;
            mem_addr        <= {ADDR_W{1'b0}};
            SelfWriteData   <= 32'h00000000;
            SelfWriteStrobe <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            words_written   <= {LEN_W{1'b0}};
        end else if (abort && (state_r != ST_IDLE)) begin
            // A strobe already on the wire this cycle still counts as issued.
            if (state_r == ST_STROBE) begin
                words_written <= words_written + LEN_W'(1);
            end
            state_r         <= ST_IDLE;
            mem_rd_en       <= 1'b0;
            SelfWriteStrobe <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        len_r <= len_words;
                        if (len_words == {LEN_W{1'b0}}) begin
                            done <= 1'b1;
                        end else begin
                            done          <= 1'b0;
                            words_written <= {LEN_W{1'b0}};
                            busy          <= 1'b1;
                            mem_rd_en     <= 1'b1;
                            mem_addr      <= base_addr;
                            cnt_r         <= {CNT_W{1'b0}};
                            state_r       <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r < CNT_W'(3)) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    if (cnt_r == CNT_W'(3)) begin
                        mem_rd_en <= 1'b0;
                    end
                    if ((cnt_r != CNT_W'(0)) && (cnt_r != CNT_W'(4))) begin
                        bytes_r <= {bytes_r[15:0], mem_rdata};
                    end
                    if (cnt_r == CNT_W'(4)) begin
                        SelfWriteData <= pack_word(bytes_r, mem_rdata);
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == CNT_W'(SETUP_CYCLES - 1)) begin
                        cnt_r           <= {CNT_W{1'b0}};
                        SelfWriteStrobe <= 1'b1;
                        state_r         <= ST_STROBE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    SelfWriteStrobe <= 1'b0;
                    words_written   <= words_written + LEN_W'(1);
                    cnt_r           <= {CNT_W{1'b0}};
                    state_r         <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_r <= {CNT_W{1'b0}};
                        // mem_addr still points at the last byte of this word.
                        if (words_written < len_r) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            state_r   <= ST_FETCH;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    mem_rd_en       <= 1'b0;
                    SelfWriteStrobe <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_self_write_loader.sv
// Bench for bitstream_self_write_loader: timeline model derived from the word period
// and the edge-relative schedule, plus directed runs with literal expectations.
module tb_bitstream_self_write_loader;

    logic        CLK;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [13:0] base_addr;
    logic [11:0] len_words;
    logic        mem_rd_en;
    logic [13:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] SelfWriteData;
    logic        SelfWriteStrobe;
    logic        busy;
    logic        done;
    logic [11:0] words_written;

    bitstream_self_write_loader dut (
        .CLK(CLK), .resetn(resetn), .start(start), .abort(abort),
        .base_addr(base_addr), .len_words(len_words),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
        .busy(busy), .done(done), .words_written(words_written)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] mem [0:16383];
    always @(posedge CLK) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int b, input int w);
        int a;
        a = b + 4 * w;
        return {mem[a % 16384], mem[(a + 1) % 16384], mem[(a + 2) % 16384], mem[(a + 3) % 16384]};
    endfunction

    // Model: every output is a function of edges elapsed since start acceptance.
    bit          m_active;
    int          m_rel, m_n, m_base;
    logic        exp_rd, exp_strobe, exp_busy, exp_done;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;
    logic [11:0] exp_ww;

    task automatic model_at_rel();
        int w, p;
        w = m_rel / 10;
        p = m_rel % 10;
        exp_rd     = (p < 4);
        exp_addr   = 14'((m_base + 4 * w + p) % 16384);
        exp_strobe = (p == 7);
        exp_ww     = 12'((m_rel + 2) / 10);
        if (p == 5) exp_data = word_at(m_base, w);
    endtask

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_active = 1'b0; exp_rd = 1'b0; exp_addr = 14'h0; exp_strobe = 1'b0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_data = 32'h0; exp_ww = 12'h0;
        end else if (m_active) begin
            m_rel++;
            if (abort) begin
                m_active = 1'b0; exp_rd = 1'b0; exp_strobe = 1'b0; exp_busy = 1'b0;
                exp_ww = 12'((m_rel + 2) / 10);
            end else if (m_rel == 10 * m_n) begin
                m_active = 1'b0; exp_rd = 1'b0; exp_strobe = 1'b0; exp_busy = 1'b0;
                exp_done = 1'b1; exp_ww = 12'(m_n);
            end else begin
                model_at_rel();
            end
        end else if (start && !abort) begin
            m_n    = int'(len_words);
            m_base = int'(base_addr);
            if (m_n == 0) begin
                exp_done = 1'b1;
            end else begin
                m_active = 1'b1; m_rel = 0; exp_busy = 1'b1; exp_done = 1'b0;
                model_at_rel();
            end
        end
    end

    // Per-cycle compare plus setup/hold spacing around every strobe.
    int ncyc = 0, last_chg = -100, last_stb = -100, n_stb = 0, n_rd = 0;
    logic [31:0] prev_data = 32'h0;
    always @(negedge CLK) begin
        ncyc++;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("strobe", 32'(SelfWriteStrobe), 32'(exp_strobe));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
            chk("words_written", 32'(words_written), 32'(exp_ww));
            chk("data", SelfWriteData, exp_data);
            if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        end
        if (!resetn) begin
            prev_data = SelfWriteData; last_chg = -100; last_stb = -100;
        end else begin
            if (SelfWriteData !== prev_data) begin
                chk("hold_time", 32'(ncyc - last_stb >= 3), 32'd1);
                last_chg = ncyc;
                prev_data = SelfWriteData;
            end
            if (SelfWriteStrobe) begin
                chk("setup_time", 32'(ncyc - last_chg >= 2), 32'd1);
                last_stb = ncyc;
                n_stb++;
            end
            if (mem_rd_en) n_rd++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [13:0] b, input logic [11:0] l);
        base_addr = b; len_words = l; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, SelfWriteData, 32'h0);
        chk({tag, "_strobe"}, 32'(SelfWriteStrobe), 32'd0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ww"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 14'h0; len_words = 12'h0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        repeat (2) @(posedge CLK);
        #1 chk_en = 1'b1;
        chk_all_zero("reset");
        #2 resetn = 1'b1;
        wait_cyc(2);

        // Single word DEADBEEF
        mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
        n_stb = 0;
        go(14'h0000, 12'd1);
        wait_cyc(5);
        chk("w1_data_E5", SelfWriteData, 32'hDEADBEEF);
        wait_cyc(5);
        chk("w1_done", 32'(done), 32'd1);
        chk("w1_busy", 32'(busy), 32'd0);
        chk("w1_ww", 32'(words_written), 32'd1);
        chk("w1_strobes", 32'(n_stb), 32'd1);

        // Three words wrapping past the top of memory
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        n_stb = 0;
        go(14'h3FFC, 12'd3);
        wait_cyc(7);
        chk("wrap_stb0", 32'(SelfWriteStrobe), 32'd1);
        chk("wrap_w0", SelfWriteData, 32'hFCFDFEFF);
        wait_cyc(10);
        chk("wrap_stb1", 32'(SelfWriteStrobe), 32'd1);
        chk("wrap_w1", SelfWriteData, 32'h00010203);
        wait_cyc(10);
        chk("wrap_stb2", 32'(SelfWriteStrobe), 32'd1);
        chk("wrap_w2", SelfWriteData, 32'h04050607);
        wait_cyc(3);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_strobes", 32'(n_stb), 32'd3);

        // Abort during the second word's fetch
        n_stb = 0;
        go(14'h0000, 12'd4);
        wait_cyc(12);
        abort = 1'b1;
        wait_cyc(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        wait_cyc(10);
        chk("abort_ww", 32'(words_written), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_strobes", 32'(n_stb), 32'd1);

        // Zero length completes at once with no traffic
        n_stb = 0; n_rd = 0;
        go(14'h0040, 12'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        wait_cyc(5);
        chk("zero_reads", 32'(n_rd), 32'd0);
        chk("zero_strobes", 32'(n_stb), 32'd0);

        // start together with abort in IDLE is ignored
        base_addr = 14'h0; len_words = 12'd3; start = 1'b1; abort = 1'b1;
        wait_cyc(1);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", 32'(busy), 32'd0);

        // Normal run after abort, with start pulsed while busy
        n_stb = 0;
        go(14'h0020, 12'd2);
        wait_cyc(3);
        base_addr = 14'h0; len_words = 12'd7; start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(16);
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_ww", 32'(words_written), 32'd2);
        chk("busy_start_strobes", 32'(n_stb), 32'd2);
        chk("busy_start_data", SelfWriteData, 32'h24252627);

        // Asynchronous reset while the strobe is high
        go(14'h0000, 12'd2);
        wait_cyc(7);
        chk("pre_reset_strobe", 32'(SelfWriteStrobe), 32'd1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(posedge CLK);
        #3 resetn = 1'b1;
        wait_cyc(3);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_ww", 32'(words_written), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
